// File: rtl/m139_reader_if.sv
// m139_reader_if: request, response and PROM signals of the m139 PROM reader.
// Latency: none, wires only.
// Backpressure: req_ready gates requests; responses and the PROM side have none.
interface m139_reader_if;
  logic       req_valid;
  logic [8:0] req_addr;
  logic       req_ready;
  logic       rsp_valid;
  logic [8:0] rsp_addr;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [8:0] prom_addr;
  logic       prom_cs_n;
  logic [3:0] prom_q;
  logic       prom_rdy_n;

  // The reader's own view: it consumes requests and PROM data, and produces the rest.
  modport master (
    input  req_valid, req_addr, prom_q, prom_rdy_n,
    output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_err, prom_addr, prom_cs_n
  );

  // The environment's view: the requester, the response sink and the PROM.
  modport slave (
    output req_valid, req_addr, prom_q, prom_rdy_n,
    input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_err, prom_addr, prom_cs_n
  );
endinterface

// File: rtl/m139_reader.sv
// m139_reader: PROM chip-select initiator fed by a 2-entry request FIFO (sync_fifo below).
// Latency: rsp_valid three edges after request accept; back-to-back lookups launch every 3 cycles.
// Backpressure: req_ready low while two requests are queued; the response strobe cannot be stalled.
// Optional M139_READER_TIMEOUT_EN: abort a lookup after TIMEOUT cycles in SEL with rsp_err set.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_dat = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; callers never push when full nor pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module m139_reader #(
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  m139_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEL = 2'd1, CAP = 2'd2, REL = 2'd3} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [8:0] fifo_dat;
  logic       fifo_push;
  logic       fifo_empty;
  logic       fifo_full;
  logic       launch;
  logic       capture;
  logic       abort;
  logic       tmo_hit;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("m139_reader: TIMEOUT must lie in 2..255");
  end

  assign bus.req_ready = !fifo_full;
  assign fifo_push     = bus.req_valid && bus.req_ready;

  sync_fifo #(.WIDTH(9), .DEPTH(2)) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (bus.req_addr),
    .pop      (launch),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

`ifdef M139_READER_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Give up on the PROM once the last allowed SEL cycle also sees rdy_n high.
  assign tmo_hit = bus.prom_rdy_n && (tmo_cnt == 8'(TIMEOUT - 1));

  // Count SEL cycles spent waiting for the PROM; restarts with every launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 tmo_cnt <= '0;
    else if (launch)                            tmo_cnt <= '0;
    else if (state == SEL && bus.prom_rdy_n)    tmo_cnt <= tmo_cnt + 8'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; rdy_n is only looked at in SEL, so the release pulse lands harmlessly in REL.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SEL;
      SEL:     if (!bus.prom_rdy_n) state_nxt = CAP;
               else if (tmo_hit)    state_nxt = REL;
      CAP:     state_nxt = REL;
      REL:     state_nxt = fifo_empty ? IDLE : SEL;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state actions: launch pops the FIFO, capture/abort end the lookup.
  always_comb begin
    launch  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE, REL: launch  = !fifo_empty;
      SEL:       abort   = tmo_hit;
      CAP:       capture = 1'b1;
      default:   ;
    endcase
  end

  // PROM address/select are registered; the address only moves on launch, so it is stable under cs_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.prom_addr <= '0;
      bus.prom_cs_n <= 1'b1;
    end else if (launch) begin
      bus.prom_addr <= fifo_dat;
      bus.prom_cs_n <= 1'b0;
    end else if (capture || abort) begin
      bus.prom_cs_n <= 1'b1;
    end
  end

  // One-cycle response strobe; the result fields hold until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_addr  <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= capture || abort;
      if (capture) begin
        bus.rsp_addr <= bus.prom_addr;
        bus.rsp_data <= bus.prom_q;
      end else if (abort) begin
        bus.rsp_addr <= bus.prom_addr;
        bus.rsp_data <= '0;
      end
    end
  end

`ifdef M139_READER_TIMEOUT_EN
  // Error flag travels with the response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bus.rsp_err <= 1'b0;
    else if (capture) bus.rsp_err <= 1'b0;
    else if (abort)   bus.rsp_err <= 1'b1;
  end
`else
  assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_m139_reader.sv
// tb_m139_reader: randomized scoreboard bench for m139_reader with a behavioural PROM responder.
// Latency: expected response edge derived from accept edge and previous response edge.
// Backpressure: req_ready predicted from the number of accepted, not yet launched requests.
module tb_m139_reader;
  localparam int TB_TIMEOUT = 4;

  typedef struct {
    logic [8:0] addr;
    logic [3:0] data;
    logic       err;
    int         launch;
    int         rsp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  m139_reader_if bus();

  m139_reader #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // PROM responder: rdy_n low for the cycle after any cs_n edge, data one cycle after rdy_n.
  logic [3:0] prom_mem [512];
  logic       cs_prev = 1'b1;
  logic [3:0] q_reg = 4'h0;
  logic       stub_mute = 1'b0;

  assign bus.prom_rdy_n = stub_mute | (bus.prom_cs_n == cs_prev);
  assign bus.prom_q     = q_reg;

  always @(posedge clk) begin
    if (!bus.prom_rdy_n && !bus.prom_cs_n) q_reg <= prom_mem[bus.prom_addr];
    cs_prev <= bus.prom_cs_n;
  end

  // Scoreboard state.
  exp_t       exp_q[$];
  int         edge_n = 0;
  int         last_rsp = -100;
  int         rd_idx = 0;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] held_addr = '0;
  logic [3:0] held_data = '0;
  logic       held_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: every accepted request is launched one edge after accept or after the
  // previous response, whichever is later, and answers 2 edges later (TIMEOUT when muted).
  always @(posedge clk) begin : sb_accept
    exp_t e;
    edge_n++;
    if (!rst_n) begin
      last_rsp = -100;
    end else if (bus.req_valid && bus.req_ready) begin
      e.addr   = bus.req_addr;
      e.err    = stub_mute;
      e.data   = stub_mute ? 4'h0 : prom_mem[bus.req_addr];
      e.launch = (edge_n + 1 > last_rsp + 1) ? edge_n + 1 : last_rsp + 1;
      e.rsp    = e.launch + (stub_mute ? TB_TIMEOUT : 2);
      last_rsp = e.rsp;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares outputs against the model between edges.
  always @(negedge clk) begin : monitor
    int   pend;
    bit   act_found;
    exp_t act_e;
    if (!rst_n) begin
      rd_idx    = exp_q.size();
      held_addr = '0;
      held_data = '0;
      held_err  = 1'b0;
    end else begin
      pend      = 0;
      act_found = 1'b0;
      for (int i = rd_idx; i < exp_q.size(); i++) begin
        if (exp_q[i].launch > edge_n) pend++;
        else if (exp_q[i].rsp > edge_n && !act_found) begin
          act_found = 1'b1;
          act_e     = exp_q[i];
        end
      end
      chk("req_ready", bus.req_ready, pend < 2);
      chk("prom_cs_n", bus.prom_cs_n, !act_found);
      if (act_found) chk("prom_addr", bus.prom_addr, act_e.addr);
      if (bus.rsp_valid) begin
        if (rd_idx >= exp_q.size()) begin
          chk("rsp_unexpected", bus.rsp_valid, 1'b0);
        end else begin
          chk("rsp_edge", edge_n, exp_q[rd_idx].rsp);
          chk("rsp_addr", bus.rsp_addr, exp_q[rd_idx].addr);
          chk("rsp_data", bus.rsp_data, exp_q[rd_idx].data);
          chk("rsp_err", bus.rsp_err, exp_q[rd_idx].err);
          held_addr = exp_q[rd_idx].addr;
          held_data = exp_q[rd_idx].data;
          held_err  = exp_q[rd_idx].err;
          rd_idx++;
        end
      end else begin
        chk("rsp_hold", {bus.rsp_addr, bus.rsp_data, bus.rsp_err}, {held_addr, held_data, held_err});
        if (rd_idx < exp_q.size() && exp_q[rd_idx].rsp <= edge_n) begin
          chk("rsp_missing", bus.rsp_valid, 1'b1);
          rd_idx++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one request and hold it until accepted; call at a negedge.
  task automatic send(input logic [8:0] a);
    int guard;
    guard = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_accept_wait", bus.req_ready, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int g;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    for (int i = 0; i < 512; i++) prom_mem[i] = 4'($urandom_range(0, 15));
    prom_mem[9'h000] = 4'h7;
    prom_mem[9'h040] = 4'hE;
    prom_mem[9'h080] = 4'hD;
    prom_mem[9'h1FE] = 4'hB;
    prom_mem[9'h1F0] = 4'h7;
    prom_mem[9'h0FF] = 4'hD;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_cs_n", bus.prom_cs_n, 1'b1);
    chk("reset_prom_addr", bus.prom_addr, 9'h000);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_addr", bus.rsp_addr, 9'h000);
    chk("reset_rsp_data", bus.rsp_data, 4'h0);
    chk("reset_rsp_err", bus.rsp_err, 1'b0);
    chk("reset_req_ready", bus.req_ready, 1'b1);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // Single lookup.
    send(9'h000);
    idle(6);

    // Back-to-back decode, FIFO fills and req_valid is held while full.
    send(9'h040);
    send(9'h080);
    send(9'h1FE);
    send(9'h1F0);
    idle(12);

    // Continuous random burst, then randomly gapped traffic.
    for (int i = 0; i < 6; i++) send(9'($urandom_range(0, 511)));
    for (int i = 0; i < 40; i++) begin
      send(9'($urandom_range(0, 511)));
      idle($urandom_range(0, 3));
    end
    idle(10);

`ifdef M139_READER_TIMEOUT_EN
    // PROM never answers: the lookup must abort with an error response.
    stub_mute = 1'b1;
    send(9'h100);
    idle(TB_TIMEOUT + 4);
    stub_mute = 1'b0;
    idle(4);
`endif

    // Reset mid-lookup: 0x010 in SEL with 0x020 queued behind it.
    send(9'h010);
    send(9'h020);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", bus.prom_cs_n, 1'b1);
    chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("midrst_req_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    idle(10);
    send(9'h0FF);
    idle(8);

    // Drain: every expected response must have been seen.
    g = 0;
    while (rd_idx < exp_q.size() && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", rd_idx, exp_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/m139_reader.md
# m139_reader

Initiator for the 512×4 address-decode PROM responder (`cs_n`/`addr`/`q`/`rdy_n` handshake).
- Accepts lookup requests from the memory-map controller and buffers them in a 2-entry FIFO.
- Sequences the PROM chip-select handshake, ignoring the release pulse on `rdy_n`.
- Returns the 4-bit active-low select nibble with its address.
- Sits between the FM-7 bus decoder and the PROM model.

## Interface
- `TIMEOUT`, 15: cycles in SEL without `prom_rdy_n` low before an error response; range 2..255.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_addr`  in  9  PROM address to look up.
- `req_ready`  out  1  FIFO not full; combinational from the FIFO count.
- `rsp_valid`  out  1  one-cycle result strobe; no backpressure.
- `rsp_addr`  out  9  address of the returned result.
- `rsp_data`  out  4  captured PROM nibble.
- `rsp_err`  out  1  the lookup timed out; `rsp_data` is 0.
- `prom_addr`  out  9  address to the PROM; registered.
- `prom_cs_n`  out  1  PROM select, active-low; registered.
- `prom_q`  in  4  PROM data; valid one cycle after `prom_rdy_n` is sampled low.
- `prom_rdy_n`  in  1  PROM ready, active-low.
  - Pulses low for one cycle after each `cs_n` edge.

## Operation
- **Request FIFO:** 2 entries, 9 bits wide.
  - Push on `req_valid && req_ready`; pop when the FSM launches a lookup.
  - Push and pop on the same edge leave the count unchanged.
  - `req_ready` = count < 2.
- **FSM states:** IDLE, SEL, CAP, REL.
- **IDLE:**
  - FIFO empty: hold.
  - FIFO non-empty: pop to `prom_addr`, `prom_cs_n` <= 0, clear the timeout counter, go to SEL.
- **SEL:**
  - `prom_rdy_n` sampled 0: go to CAP.
  - Otherwise: increment the timeout counter.
- **CAP:**
  - Register `rsp_data` <= `prom_q`, `rsp_addr` <= `prom_addr`, `rsp_err` <= 0.
  - Pulse `rsp_valid` for one cycle.
  - `prom_cs_n` <= 1; go to REL.
- **REL:** exists only to absorb the release low pulse on `prom_rdy_n`; `prom_rdy_n` is not examined.
  - FIFO non-empty: launch the next lookup exactly as IDLE does (go to SEL).
  - FIFO empty: go to IDLE.
- `prom_rdy_n` low while in IDLE or REL is ignored.
- **Reset:** asynchronous; takes effect immediately, including mid-lookup.
  - Outputs: `prom_cs_n`=1, `prom_addr`=0, `rsp_valid`=0, `rsp_addr`=0, `rsp_data`=0, `rsp_err`=0.
  - Internal: FIFO empty (so `req_ready`=1), FSM in IDLE, timeout counter 0.
  - An aborted lookup produces no response.

## Timing
- **Single request:** accepted at edge E0.
  - E1: `prom_cs_n` falls.
  - E2: `prom_rdy_n`=0 is sampled.
  - E3: `rsp_valid`=1 for one cycle, and `prom_cs_n` rises.
  - E4: FSM returns to IDLE.
- **Latency:** `rsp_valid` asserts 3 edges after the accept edge.
- **Throughput:** back-to-back lookups launch every 3 cycles (SEL, CAP, REL).
  - The REL→SEL transition re-asserts `prom_cs_n` the cycle after it rose.
  - The PROM sees a falling edge and pulses `rdy_n` again.
- `prom_addr` is stable for the whole time `prom_cs_n` is low.
- `rsp_*` fields hold their values until the next response.

## Configuration
- **`M139_READER_TIMEOUT_EN` defined:**
  - In SEL with the counter at `TIMEOUT`-1 and `prom_rdy_n`=1 at an edge, the lookup aborts.
  - `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0, `rsp_addr`=failed address.
  - `prom_cs_n` <= 1; go to REL.
  - The error strobe therefore appears `TIMEOUT` cycles after SEL is entered.
- **Undefined:**
  - No counter is built; SEL waits indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- **Single lookup:** request 0x000 accepted at E0, PROM model attached -> `rsp_valid` at E3 with `rsp_data`=0x7, `rsp_addr`=0x000, `rsp_err`=0; `prom_cs_n` low for exactly 2 cycles.
- **Back-to-back decode:** requests 0x040, 0x080, 0x1FE, 0x1F0 pushed continuously.
  - Responses are 0xE, 0xD, 0xB, 0x7, in order, 3 cycles apart.
  - `req_ready` drops when 2 entries are queued.
- **FIFO full with simultaneous pop:** fill to 2 entries, hold `req_valid`.
  - No push occurs while `req_ready`=0.
  - A push occurs the cycle after a pop frees an entry.
  - No request is lost or duplicated.
- **Timeout** (macro defined, `TIMEOUT`=4): stub holds `prom_rdy_n`=1, request 0x100.
  - `rsp_valid`=1 with `rsp_err`=1, `rsp_data`=0, `rsp_addr`=0x100, 4 cycles after SEL entry.
  - `prom_cs_n` returns high on the same edge.
- **Reset mid-lookup:** assert `rst_n`=0 while in SEL with one request queued.
  - `prom_cs_n`=1 and `rsp_valid`=0 immediately (no clock edge needed); `req_ready`=1.
  - After release, no response is produced.
  - A new request to 0x0FF returns 0xD.
